// File: rtl/qspi_collector_pkg.sv
// qspi_collector_pkg
// Shared types and elaboration-time helpers for the QSPI collector.
//   state_t     : collector FSM states (SCAN / TAG / SEND)
//   beat_count  : number of LANE_W beats needed to carry one DATA_W packet
//   cnt_width   : beat counter width for a given beat count
package qspi_collector_pkg;

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_TAG  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic int beat_count(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    // One spare bit so the counter can step past the last beat without aliasing.
    function automatic int cnt_width(input int beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/qspi_collector_lane_serializer.sv
// lane_serializer
// Parallel-in shift register that emits one packet LSB-first in LANE_W-bit beats.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   load         : capture load_data and restart the beat counter
//   load_data    : DATA_W-bit packet to serialise
//   send         : collector is presenting data beats (acts as beat valid)
//   ready        : downstream accepts the current beat
//   beat         : current LANE_W-bit beat
//   last         : current beat is the final beat of the packet
//   done         : final beat transfers on this clock edge
module lane_serializer
    import qspi_collector_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              send,
    input  logic              ready,
    output logic [LANE_W-1:0] beat,
    output logic              last,
    output logic              done
);

    localparam int BEATS = beat_count(DATA_W, LANE_W);
    localparam int CNT_W = cnt_width(BEATS);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
        end else if (send && ready) begin
            shreg_d = shreg_q >> LANE_W;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Beat and last only move on a transfer, so they stay stable while stalled.
    assign beat = shreg_q[LANE_W-1:0];
    assign last = (cnt_q == CNT_W'(BEATS - 1));
    assign done = send && ready && last;

endmodule

// File: rtl/qspi_collector.sv
// qspi_collector
// Round-robin arbiter over NUM_CH encrypter channels. Captures one packet at a
// time, optionally emits a channel-index tag beat, then serialises the packet
// LSB-first onto a LANE_W-bit valid/ready stream.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   ch_data     : packed packets, channel i at [i*DATA_W +: DATA_W]
//   ch_valid    : per-channel packet available
//   ch_ack      : one-cycle capture pulse back to the served channel
//   qspi_data   : current beat (tag or data)
//   qspi_valid  : beat valid
//   qspi_last   : final data beat of the packet
//   qspi_ready  : downstream accepts beat
//   busy        : a packet is held (TAG or SEND)
//   cur_ch      : channel being served, or round-robin pointer while scanning
module qspi_collector
    import qspi_collector_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 4,
    parameter int SKIP_IDLE = 1,
    parameter int TAG_EN    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic [LANE_W-1:0]         qspi_data,
    output logic                      qspi_valid,
    output logic                      qspi_last,
    input  logic                      qspi_ready,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] cur_ch
);

    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("qspi_collector: NUM_CH must be at least 2");
    end
    if (DATA_W % LANE_W != 0) begin : g_bad_lane
        $error("qspi_collector: DATA_W must be a multiple of LANE_W");
    end
    if (TAG_EN != 0 && CH_W > LANE_W) begin : g_bad_tag
        $error("qspi_collector: channel index does not fit in one tag beat");
    end

    state_t            state_q, state_d;
    logic [CH_W-1:0]   cur_q, cur_d;
    logic [NUM_CH-1:0] ack_q, ack_d;

    logic [DATA_W-1:0] ch_pkt [NUM_CH];
    logic              found;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   cand;
    int                idx;
    logic              load;
    logic [LANE_W-1:0] ser_beat;
    logic              ser_last;
    logic              ser_done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_pkt[i] = ch_data[i*DATA_W +: DATA_W];
    end

    // Cyclic search from the pointer; walking offsets high-to-low lets the
    // smallest offset overwrite the selection last, so it wins.
    always_comb begin
        found = 1'b0;
        sel   = cur_q;
        idx   = 0;
        cand  = '0;
        if (SKIP_IDLE != 0) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = int'(cur_q) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                cand = CH_W'(idx);
                if (ch_valid[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end else begin
            found = ch_valid[cur_q];
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ack_d   = '0;
        load    = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (found) begin
                    load       = 1'b1;
                    cur_d      = sel;
                    ack_d[sel] = 1'b1;
                    state_d    = (TAG_EN != 0) ? ST_TAG : ST_SEND;
                end
            end
            ST_TAG: begin
                if (qspi_ready) state_d = ST_SEND;
            end
            ST_SEND: begin
                // Returning through SCAN guarantees a valid-low gap between packets.
                if (ser_done) begin
                    state_d = ST_SCAN;
                    cur_d   = (cur_q == CH_W'(NUM_CH - 1)) ? '0 : cur_q + CH_W'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCAN;
            cur_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ack_q   <= ack_d;
        end
    end

    lane_serializer #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (ch_pkt[sel]),
        .send      (state_q == ST_SEND),
        .ready     (qspi_ready),
        .beat      (ser_beat),
        .last      (ser_last),
        .done      (ser_done)
    );

    always_comb begin
        qspi_data = '0;
        if (state_q == ST_TAG)  qspi_data = LANE_W'(cur_q);
        if (state_q == ST_SEND) qspi_data = ser_beat;
    end

    assign qspi_valid = (state_q != ST_SCAN);
    assign qspi_last  = (state_q == ST_SEND) && ser_last;
    assign busy       = (state_q != ST_SCAN);
    assign ch_ack     = ack_q;
    assign cur_ch     = cur_q;

endmodule

// File: doc/qspi_collector.md
Name: qspi_collector

Overview:
Parametrised successor to the fixed 4-bit encrypter collector. Arbitrates among NUM_CH encrypter outputs, captures one DATA_W-bit packet at a time and serialises it onto a LANE_W-bit QSPI-side stream with a valid/ready handshake. Adds selectable lane width, a skip-idle round-robin mode and an optional channel-ID tag beat. Sits between the encrypter array and the QSPI transmitter.

Parameters:
NUM_CH, 4, number of encrypter channels (>=2)
DATA_W, 32, packet width per channel; must be a multiple of LANE_W
LANE_W, 4, beat width on the QSPI side (1, 2, 4 or 8)
SKIP_IDLE, 1, 0 = strict round robin (wait on pointer channel); 1 = serve first valid channel at or after pointer
TAG_EN, 1, 1 = prepend one tag beat carrying the channel index; requires clog2(NUM_CH) <= LANE_W

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
ch_data  in  NUM_CH*DATA_W  packed channel packets, channel i at bits [i*DATA_W +: DATA_W]
ch_valid  in  NUM_CH  channel i has a packet ready
ch_ack  out  NUM_CH  one-cycle capture pulse to channel i
qspi_data  out  LANE_W  current beat
qspi_valid  out  1  beat valid
qspi_last  out  1  current beat is the last of the packet
qspi_ready  in  1  QSPI transmitter accepts beat
busy  out  1  packet held (TAG or SEND state)
cur_ch  out  clog2(NUM_CH)  channel being served / round-robin pointer

Behaviour:
- Reset (async assert, sync deassert internally): state=SCAN, pointer=0, ch_ack=0, qspi_data=0, qspi_valid=0, qspi_last=0, busy=0, cur_ch=0. Packet in flight discarded; no ack issued.
- States: SCAN, TAG, SEND.
- SCAN: SKIP_IDLE=0: capture when ch_valid[pointer]=1, else stay. SKIP_IDLE=1: select lowest index j in cyclic order pointer, pointer+1, ... with ch_valid[j]=1; none -> stay. Capture edge: shift register <= ch_data[j], cur_ch <= j, ch_ack[j]=1 for exactly the next cycle, next state TAG if TAG_EN else SEND.
- Producer must drop or replace ch_valid in the cycle ch_ack is high; collector never samples a channel outside SCAN.
- TAG: qspi_data = cur_ch zero-extended, qspi_valid=1, qspi_last=0. On valid&&ready -> SEND.
- SEND: BEATS = DATA_W/LANE_W beats, LSB-first: beat k = packet[k*LANE_W +: LANE_W]. Beat counter width clog2(BEATS)+1. qspi_last=1 on beat BEATS-1. Beat transfers on rising edge with valid&&ready; while valid&&!ready, qspi_data/qspi_last held stable.
- Last beat transfer: pointer <= cur_ch+1, wrapping NUM_CH-1 -> 0; state -> SCAN; qspi_valid low for at least one cycle between packets (minimum packet period = BEATS+TAG_EN+1 cycles with ready stuck high).
- qspi_ready high while qspi_valid low: ignored.
- Only one ch_ack bit ever high; ch_ack never high outside the cycle after capture.
- Elaboration check: DATA_W % LANE_W != 0 or tag width violation -> $error.

Decomposition:
- Package qspi_collector_pkg: state enum (SCAN/TAG/SEND), clog2-derived width constants, beat-count function.
- Sub-module lane_serializer: parallel-in, LANE_W-out shift register with valid/ready/last and beat counter; collector owns arbitration, tag and ack.

Test Plan:
- NUM_CH=4, DATA_W=32, LANE_W=4, TAG_EN=1; ch2 valid with 0xDEADBEEF, ready=1 -> ch_ack=4'b0100 one cycle; beats 2,F,E,E,B,D,A,E,D; qspi_last only on final D; pointer=3 afterwards.
- Same packet, qspi_ready low for 4 cycles at third data beat -> qspi_data holds 0xE stable, valid stays high, no beat dropped or duplicated.
- All four ch_valid held high, each refilled after ack -> tag sequence 0,1,2,3,0,1; every ch_ack bit pulses once per round.
- Pointer=0, only ch1 valid: SKIP_IDLE=0 -> no output until ch0 valid, then ch0 served before ch1; SKIP_IDLE=1 -> ch1 served immediately (tag 1).
- Assert reset after fourth data beat -> all outputs 0 asynchronously; after release, ch3 valid -> full packet from beat 0 with tag 3; no ack for the aborted packet's channel.
- LANE_W=1, DATA_W=8, TAG_EN=0, ch0=0xA5 -> beats 1,0,1,0,0,1,0,1; qspi_last on the eighth.
